// File: rtl/uart_tx_pkg.sv
// Shared types and sizing helpers for the UART transmit stage.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_LATCH  = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } tx_state_t;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

   // Baud counter width; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned clks);
      return ($clog2(clks) < 1) ? 1 : $clog2(clks);
   endfunction

endpackage

// File: rtl/uart_tx_stage_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
module tx_baud_counter
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic Mclk,
   input  logic Reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] count;

   // tick is registered one count early so it is high exactly while count == LAST_CNT
   always_ff @(posedge Mclk or posedge Reset) begin
      if (Reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         count <= (count == LAST_CNT) ? '0 : count + CNT_W'(1);
         tick  <= (count == PRE_LAST);
      end
   end

endmodule

// File: rtl/uart_tx_stage.sv
// UART serialiser: pops one byte from the TX FIFO and sends start, 8 data bits
// LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_stage
   import uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       Mclk,
   input  logic       Reset,
   input  logic       tx_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_q,
   output logic       fifo_rdreq,
   output logic       Tx,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
   localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic                 ODD_BIT   = 1'(PARITY_ODD);

   tx_state_t             state;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  parity_q;
   logic [BIT_IDX_W-1:0]  bit_idx;
   logic                  stop_idx;
   logic                  tick;
   logic                  baud_clr_c;

   // Timer is held at zero until the start bit, then wraps at each bit boundary.
   assign baud_clr_c = (state == S_IDLE) || (state == S_READ) || (state == S_LATCH);

   tx_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .Mclk  (Mclk),
      .Reset (Reset),
      .clear (baud_clr_c),
      .tick  (tick)
   );

   always_ff @(posedge Mclk or posedge Reset) begin
      if (Reset) begin
         state      <= S_IDLE;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         Tx         <= 1'b1;
         fifo_rdreq <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               Tx <= 1'b1;
               if (tx_en && !fifo_empty) begin
                  fifo_rdreq <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_READ;
               end
            end
            S_READ: begin
               fifo_rdreq <= 1'b0;
               state      <= S_LATCH;
            end
            S_LATCH: begin
               shift_q  <= fifo_q;
               parity_q <= (^fifo_q) ^ ODD_BIT;
               Tx       <= 1'b0;
               state    <= S_START;
            end
            S_START: begin
               if (tick) begin
                  Tx      <= shift_q[0];
                  bit_idx <= '0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
                     if (PARITY_EN != 0) begin
                        Tx    <= parity_q;
                        state <= S_PARITY;
                     end else begin
                        Tx       <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= S_STOP;
                     end
                  end else begin
                     shift_q <= shift_q >> 1;
                     Tx      <= shift_q[1];
                     bit_idx <= bit_idx + BIT_IDX_W'(1);
                  end
               end
            end
            S_PARITY: begin
               if (tick) begin
                  Tx       <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= S_STOP;
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (stop_idx == LAST_STOP) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state      <= S_IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               Tx         <= 1'b1;
               fifo_rdreq <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage: four instances at CLKS_PER_BIT=4 covering
// plain 8N1, even parity, odd parity and two stop bits.
module tb_uart_tx_stage;

   // Bit k of each sequence is the k-th line bit (start first), hand-derived.
   localparam logic [15:0] SEQ_A5  = 16'b0000_0011_0100_1010;  // 0,1,0,1,0,0,1,0,1,1
   localparam logic [15:0] SEQ_00  = 16'b0000_0010_0000_0000;
   localparam logic [15:0] SEQ_FF  = 16'b0000_0011_1111_1110;
   localparam logic [15:0] SEQ_07E = 16'b0000_0110_0000_1110;  // parity bit 1
   localparam logic [15:0] SEQ_07O = 16'b0000_0100_0000_1110;  // parity bit 0
   localparam logic [15:0] SEQ_3C  = 16'b0000_0110_0111_1000;  // two stop bits
   localparam logic [15:0] SEQ_5A  = 16'b0000_0010_1011_0100;
   localparam logic [15:0] SEQ_C3  = 16'b0000_0011_1000_0110;

   logic       Mclk  = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] tx_en = 4'd0;
   logic [3:0] fifo_empty;
   logic [3:0] rdreq, tx, busy, done;
   logic [7:0] fifo_q [4] = '{default: 8'd0};
   logic [7:0] fmem [4][16];
   logic [3:0] fwr [4] = '{default: 4'd0};
   logic [3:0] frd [4] = '{default: 4'd0};

   int   total = 0;
   int   bad   = 0;
   logic samp [0:255];
   int   cap_len, n_rd, n_done, n_dbl, n_rde, n_low, done_idx, f, f2;
   logic busy_at_done, prev_rd;

   always #5 Mclk = ~Mclk;

   // Normal-mode FIFO model: data appears on the edge that sees rdreq.
   always @(posedge Mclk) begin
      for (int i = 0; i < 4; i++) begin
         if (rdreq[i]) begin
            fifo_q[i] <= fmem[i][frd[i]];
            frd[i]    <= frd[i] + 4'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) fifo_empty[i] = (fwr[i] == frd[i]);
   end

   uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .Mclk(Mclk), .Reset(Reset), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
      .fifo_q(fifo_q[0]), .fifo_rdreq(rdreq[0]), .Tx(tx[0]), .busy(busy[0]),
      .frame_done(done[0]));

   uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .Mclk(Mclk), .Reset(Reset), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
      .fifo_q(fifo_q[1]), .fifo_rdreq(rdreq[1]), .Tx(tx[1]), .busy(busy[1]),
      .frame_done(done[1]));

   uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
      .Mclk(Mclk), .Reset(Reset), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]),
      .fifo_q(fifo_q[2]), .fifo_rdreq(rdreq[2]), .Tx(tx[2]), .busy(busy[2]),
      .frame_done(done[2]));

   uart_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
      .Mclk(Mclk), .Reset(Reset), .tx_en(tx_en[3]), .fifo_empty(fifo_empty[3]),
      .fifo_q(fifo_q[3]), .fifo_rdreq(rdreq[3]), .Tx(tx[3]), .busy(busy[3]),
      .frame_done(done[3]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] b);
      fmem[idx][fwr[idx]] = b;
      fwr[idx] = fwr[idx] + 4'd1;
   endtask

   // Sample one instance on falling edges; optionally drop tx_en after sample drop_at.
   task automatic capture(input int idx, input int n, input int drop_at);
      cap_len = n; n_rd = 0; n_done = 0; n_dbl = 0; n_rde = 0; n_low = 0;
      done_idx = -1; busy_at_done = 1'bx; prev_rd = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(negedge Mclk);
         samp[c] = tx[idx];
         if (tx[idx] !== 1'b1) n_low++;
         if (rdreq[idx]) begin
            n_rd++;
            if (prev_rd) n_dbl++;
            if (fifo_empty[idx]) n_rde++;
         end
         prev_rd = rdreq[idx];
         if (done[idx]) begin
            n_done++;
            if (done_idx < 0) done_idx = c;
            busy_at_done = busy[idx];
         end
         if (c == drop_at) tx_en[idx] = 1'b0;
      end
   endtask

   function automatic int first_zero(input int from);
      for (int i = from; i < cap_len; i++) if (i >= 0 && samp[i] === 1'b0) return i;
      return -1;
   endfunction

   function automatic logic samp_at(input int i);
      return (i >= 0 && i < cap_len) ? samp[i] : 1'bx;
   endfunction

   function automatic logic [63:0] frame_vec(input int start, input int n);
      logic [63:0] v = '0;
      for (int k = 0; k < n; k++) v[k] = (start < 0) ? 1'b0 : samp_at(start + k);
      return v;
   endfunction

   // Each line bit lasts 4 clocks, followed by tail idle-high samples.
   function automatic logic [63:0] stretch(input logic [15:0] seq, input int nbits, input int tail);
      logic [63:0] v = '0;
      for (int k = 0; k < nbits * 4; k++) v[k] = seq[k / 4];
      for (int k = nbits * 4; k < nbits * 4 + tail; k++) v[k] = 1'b1;
      return v;
   endfunction

   initial begin
      repeat (3) @(negedge Mclk);
      check("reset_outputs", 64'({tx, rdreq, busy, done}), 64'({4'hF, 4'h0, 4'h0, 4'h0}));
      Reset = 1'b0;

      // enable low with data waiting: line stays idle, no pop
      push(0, 8'hA5);
      capture(0, 100, -1);
      check("gate_no_rdreq", 64'(n_rd), 64'd0);
      check("gate_line_high", 64'(n_low), 64'd0);

      // single byte 0xA5
      tx_en[0] = 1'b1;
      capture(0, 60, -1);
      f = first_zero(0);
      check("a5_start_latency", 64'(f), 64'd2);
      check("a5_frame", frame_vec(f, 44), stretch(SEQ_A5, 10, 4));
      check("a5_rdreq_count", 64'(n_rd), 64'd1);
      check("a5_done_count", 64'(n_done), 64'd1);
      check("a5_done_pos", 64'(done_idx), 64'(f + 40));
      check("a5_busy_at_done", 64'(busy_at_done), 64'd0);

      // back-to-back 0x00, 0xFF
      push(0, 8'h00);
      push(0, 8'hFF);
      capture(0, 110, -1);
      f  = first_zero(0);
      f2 = first_zero(f + 40);
      check("b2b_frame0", frame_vec(f, 40), stretch(SEQ_00, 10, 0));
      check("b2b_gap", 64'(f2 - (f + 40)), 64'd3);
      check("b2b_frame1", frame_vec(f2, 44), stretch(SEQ_FF, 10, 4));
      check("b2b_rdreq_count", 64'(n_rd), 64'd2);
      check("b2b_done_count", 64'(n_done), 64'd2);
      check("b2b_rdreq_rules", 64'(n_dbl + n_rde), 64'd0);

      // even parity 0x07
      tx_en[1] = 1'b1;
      push(1, 8'h07);
      capture(1, 70, -1);
      f = first_zero(0);
      check("par_even_frame", frame_vec(f, 48), stretch(SEQ_07E, 11, 4));
      check("par_even_bit", 64'(samp_at(f + 37)), 64'd1);
      check("par_even_len", 64'(done_idx), 64'(f + 44));

      // odd parity 0x07
      tx_en[2] = 1'b1;
      push(2, 8'h07);
      capture(2, 70, -1);
      f = first_zero(0);
      check("par_odd_frame", frame_vec(f, 48), stretch(SEQ_07O, 11, 4));
      check("par_odd_bit", 64'(samp_at(f + 37)), 64'd0);

      // two stop bits 0x3C
      tx_en[3] = 1'b1;
      push(3, 8'h3C);
      capture(3, 70, -1);
      f = first_zero(0);
      check("stop2_frame", frame_vec(f, 48), stretch(SEQ_3C, 11, 4));
      check("stop2_done_pos", 64'(done_idx), 64'(f + 44));
      check("stop2_busy_at_done", 64'(busy_at_done), 64'd0);

      // tx_en dropped during DATA: frame completes, second byte stays queued
      push(0, 8'h5A);
      push(0, 8'h81);
      capture(0, 100, 15);
      f = first_zero(0);
      check("drop_frame", frame_vec(f, 44), stretch(SEQ_5A, 10, 4));
      check("drop_rdreq_count", 64'(n_rd), 64'd1);
      check("drop_no_second", 64'(first_zero(f + 40)), 64'(-1));

      // reset during DATA bit 3 of 0x81
      tx_en[0] = 1'b1;
      capture(0, 19, -1);
      check("rst_mid_started", 64'(first_zero(0)), 64'd2);
      Reset = 1'b1;
      #1;
      check("rst_async_outputs", 64'({tx[0], busy[0], rdreq[0]}), 64'(3'b100));
      push(0, 8'hC3);
      @(negedge Mclk);
      @(negedge Mclk);
      Reset = 1'b0;
      capture(0, 60, -1);
      f = first_zero(0);
      check("rst_restart_latency", 64'(f), 64'd2);
      check("rst_restart_frame", frame_vec(f, 44), stretch(SEQ_C3, 10, 4));
      check("rst_restart_rdreq", 64'(n_rd), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_stage.md
Name: uart_tx_stage

Overview:
- Serial transmit stage downstream of the TX FIFO, which is fed by the pre-TX write-strobe stage.
- Pops one byte at a time from the FIFO (normal-mode, registered output) and serialises it on the Tx line as an asynchronous UART frame.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Transmission is gated by an enable; status goes to the top level.

Parameters:
CLKS_PER_BIT, 434, Mclk cycles per bit (50 MHz / 115200); legal range 2..65535
PARITY_EN, 0, 1 = insert parity bit after D7
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
Mclk  input  1  system clock; all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
tx_en  input  1  transmit enable; sampled only in IDLE
fifo_empty  input  1  TX FIFO empty flag
fifo_q  input  8  TX FIFO read data; valid the cycle after fifo_rdreq is seen
fifo_rdreq  output  1  registered one-cycle FIFO pop strobe
Tx  output  1  serial line; idles high
busy  output  1  high from FIFO pop through end of last stop bit
frame_done  output  1  one-cycle pulse after last stop bit completes

Behaviour:
- Reset values (asynchronous, immediate):
  - Tx = 1, fifo_rdreq = 0, busy = 0, frame_done = 0.
  - State = IDLE; bit counter = 0; baud counter = 0.
- Reset mid-frame: the line returns high at once and the popped byte is discarded. No partial frame resumes after release.
- States: IDLE, READ, LATCH, START, DATA, PARITY, STOP.
- IDLE:
  - When tx_en = 1 and fifo_empty = 0: set fifo_rdreq <= 1 and busy <= 1, then go to READ.
  - Otherwise stay in IDLE with Tx = 1.
- READ: fifo_rdreq <= 0, go to LATCH. The FIFO presents the byte at this edge.
- LATCH: shift register <= fifo_q, parity <= ^fifo_q ^ PARITY_ODD, Tx <= 0, go to START.
- START: hold Tx = 0 for CLKS_PER_BIT cycles. Then Tx <= shift[0] and go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles; the shift register shifts right at each bit boundary.
  - After bit index 7 completes, go to PARITY if PARITY_EN = 1, else to STOP.
- PARITY: Tx = parity bit for CLKS_PER_BIT cycles.
- STOP:
  - Tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the final cycle: frame_done <= 1 for one cycle, busy <= 0, go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared at every state entry.
  - Width is clog2(CLKS_PER_BIT).
  - The bit boundary is when count = CLKS_PER_BIT-1.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles on the line.
- Back-to-back frames: minimum idle gap is 3 cycles of Tx = 1 (IDLE, READ, LATCH) between the end of a stop bit and the next start bit.
- tx_en deasserted mid-frame: the current frame completes; no further pop occurs.
- fifo_empty asserting mid-frame: has no effect on the current frame.
- fifo_rdreq never asserts while fifo_empty = 1, and never for more than one consecutive cycle.
- Tx is driven from a register only; no combinational path to the pin.

Decomposition:
- Package uart_tx_pkg:
  - state enum (7 states, 3-bit encoding);
  - DATA_BITS = 8;
  - function computing counter width from CLKS_PER_BIT.
- Sub-module tx_baud_counter:
  - Inputs: Mclk, Reset, clear.
  - Outputs: tick (one cycle at count = CLKS_PER_BIT-1).
  - Parameterised by CLKS_PER_BIT.
- The FSM, shift register and parity logic stay in uart_tx_stage.

Test Plan:
1. Single byte: CLKS_PER_BIT=4, FIFO holds 0xA5, tx_en=1.
   - fifo_rdreq pulses exactly once.
   - Tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles (40 line cycles).
   - frame_done pulses once; busy falls with it.
2. Back-to-back: FIFO holds 0x00, 0xFF.
   - Two frames with exactly 3 idle-high cycles between them.
   - 2 rdreq pulses; fifo_rdreq stays low once fifo_empty = 1.
3. Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07.
   - Parity bit = 1.
   - With PARITY_ODD=1, parity bit = 0.
   - Frame is 11 bits × CLKS_PER_BIT.
4. Two stop bits: STOP_BITS=2, byte 0x3C.
   - Stop phase is 8 cycles high at CLKS_PER_BIT=4.
   - frame_done appears on the final stop cycle edge.
5. Enable gating:
   - tx_en=0 with a non-empty FIFO: no rdreq, Tx = 1 for 100 cycles.
   - tx_en dropped during DATA: the frame completes and no second pop follows.
6. Reset mid-frame: assert Reset during DATA bit 3.
   - Tx = 1 and busy = 0 immediately, asynchronously.
   - After release with the FIFO non-empty, the next frame starts cleanly with a new rdreq pulse.
